// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: turns a UART byte stream into framed payload packets.
// Frame: SOF, LEN, LEN payload bytes, CHK where CHK = (LEN + sum(payload)) mod 256.
// A good frame is buffered whole and then replayed on a valid/ready/last stream.
// Bad length, bad checksum and inter-byte timeout each raise a one-cycle error pulse.
module uart_pkt_parser #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5,
  parameter int         TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [7:0] o_m_data,
  output logic       o_m_valid,
  output logic       o_m_last,
  input  logic       i_m_ready,
  output logic       o_err_len,
  output logic       o_err_chk,
  output logic       o_err_tout
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] BUF_HEAD = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_SEND
  } state_t;

  state_t        r_state;
  logic [7:0]    r_buf [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_wr_idx;
  logic [LW-1:0] r_rd_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tout_cnt;

  logic          r_s_ready;
  logic          r_m_valid;
  logic          r_m_last;
  logic [7:0]    r_m_data;
  logic          r_err_len;
  logic          r_err_chk;
  logic          r_err_tout;

  logic          w_accept;
  logic          w_in_frame;
  logic          w_len_ok;
  logic          w_wr_last;
  logic          w_tout_fire;
  logic [LW-1:0] w_rd_next;

  assign w_accept    = i_s_valid & r_s_ready;
  assign w_in_frame  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  assign w_len_ok    = (i_s_data != 8'd0) && (i_s_data <= 8'(MAX_LEN));
  assign w_wr_last   = (r_wr_idx == r_len - LW'(1));
  assign w_rd_next   = r_rd_idx + LW'(1);
  // A byte arriving in the same cycle the gap limit is reached wins over the timeout.
  assign w_tout_fire = w_in_frame && !w_accept && (r_tout_cnt == TW'(TIMEOUT - 1));

  assign o_s_ready  = r_s_ready;
  assign o_m_data   = r_m_data;
  assign o_m_valid  = r_m_valid;
  assign o_m_last   = r_m_last;
  assign o_err_len  = r_err_len;
  assign o_err_chk  = r_err_chk;
  assign o_err_tout = r_err_tout;

  // Payload capture into the frame buffer.
  // NOTE: the buffer has no reset; every slot is written before it can be read, and a
  // reset on a memory array would block RAM inference and cost a clear path for nothing.
  always_ff @(posedge i_clk) begin
    if ((r_state == S_PAYLOAD) && w_accept) begin
      r_buf[r_wr_idx[AW-1:0]] <= i_s_data;
    end
  end

  // Inter-byte gap counter: runs only while a frame is being received.
  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values; blocking assignments here would make results depend on block order.
  always_ff @(posedge i_clk) begin
    if (i_rst || !w_in_frame || w_accept || w_tout_fire) begin
      r_tout_cnt <= '0;
    end else begin
      r_tout_cnt <= r_tout_cnt + TW'(1);
    end
  end

  // Frame parser / replay FSM with registered stream and error outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_s_ready  <= 1'b1;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= 8'd0;
      r_err_len  <= 1'b0;
      r_err_chk  <= 1'b0;
      r_err_tout <= 1'b0;
      r_len      <= '0;
      r_wr_idx   <= '0;
      r_rd_idx   <= '0;
      r_sum      <= 8'd0;
    end else begin
      r_err_len  <= 1'b0;
      r_err_chk  <= 1'b0;
      r_err_tout <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_s_data == SOF)) begin
            r_state <= S_LEN;
          end
        end

        S_LEN: begin
          if (w_accept) begin
            if (w_len_ok) begin
              r_len    <= LW'(i_s_data);
              r_sum    <= i_s_data;
              r_wr_idx <= '0;
              r_state  <= S_PAYLOAD;
            end else begin
              r_err_len <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_tout_fire) begin
            r_err_tout <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        S_PAYLOAD: begin
          // A byte equal to SOF is plain data here; there is no resynchronisation.
          if (w_accept) begin
            r_sum    <= r_sum + i_s_data;
            r_wr_idx <= r_wr_idx + LW'(1);
            if (w_wr_last) begin
              r_state <= S_CHK;
            end
          end else if (w_tout_fire) begin
            r_err_tout <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        S_CHK: begin
          if (w_accept) begin
            if (i_s_data == r_sum) begin
              r_state   <= S_SEND;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
              r_m_data  <= r_buf[BUF_HEAD];
              r_m_last  <= (r_len == LW'(1));
              r_rd_idx  <= '0;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= S_IDLE;
            end
          end else if (w_tout_fire) begin
            r_err_tout <= 1'b1;
            r_state    <= S_IDLE;
          end
        end

        S_SEND: begin
          // Data and last only move on a completed transfer, so they hold while stalled.
          if (i_m_ready) begin
            if (r_m_last) begin
              r_state   <= S_IDLE;
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_s_ready <= 1'b1;
            end else begin
              r_rd_idx <= w_rd_next;
              r_m_data <= r_buf[w_rd_next[AW-1:0]];
              r_m_last <= (w_rd_next == r_len - LW'(1));
            end
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b1;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pkt_parser.sv
// tb_uart_pkt_parser: directed frames against a queue-based frame model that is
// compared with the DUT every cycle, plus literal checks of each scenario's output.
module tb_uart_pkt_parser;

  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SOF     = 8'hA5;
  localparam int         TIMEOUT = 100;

  logic       i_clk     = 1'b0;
  logic       i_rst     = 1'b1;
  logic [7:0] i_s_data  = 8'd0;
  logic       i_s_valid = 1'b0;
  logic       o_s_ready;
  logic [7:0] o_m_data;
  logic       o_m_valid;
  logic       o_m_last;
  logic       i_m_ready = 1'b1;
  logic       o_err_len;
  logic       o_err_chk;
  logic       o_err_tout;

  uart_pkt_parser #(
    .MAX_LEN (MAX_LEN),
    .SOF     (SOF),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_s_data   (i_s_data),
    .i_s_valid  (i_s_valid),
    .o_s_ready  (o_s_ready),
    .o_m_data   (o_m_data),
    .o_m_valid  (o_m_valid),
    .o_m_last   (o_m_last),
    .i_m_ready  (i_m_ready),
    .o_err_len  (o_err_len),
    .o_err_chk  (o_err_chk),
    .o_err_tout (o_err_tout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0] m_frame [$];
  logic [7:0] m_out   [$];
  int         m_gap   = 0;
  bit         m_armed = 1'b0;
  logic       e_ready, e_valid, e_last, e_err_len, e_err_chk, e_err_tout;
  logic [7:0] e_data;

  // Predicts the outputs after the coming edge from the inputs about to be sampled.
  task automatic model_step();
    logic [7:0] d;
    int         sum;
    e_err_len  = 1'b0;
    e_err_chk  = 1'b0;
    e_err_tout = 1'b0;
    if (i_rst) begin
      m_frame.delete();
      m_out.delete();
      m_gap   = 0;
      m_armed = 1'b1;
    end else if (m_out.size() > 0) begin
      if (i_m_ready) void'(m_out.pop_front());
    end else if (i_s_valid) begin
      d     = i_s_data;
      m_gap = 0;
      if (m_frame.size() == 0) begin
        if (d == SOF) m_frame.push_back(d);
      end else if (m_frame.size() == 1) begin
        if (d == 8'd0 || int'(d) > MAX_LEN) begin
          e_err_len = 1'b1;
          m_frame.delete();
        end else begin
          m_frame.push_back(d);
        end
      end else if (m_frame.size() < 2 + int'(m_frame[1])) begin
        m_frame.push_back(d);
      end else begin
        sum = 0;
        for (int i = 1; i < m_frame.size(); i++) sum += int'(m_frame[i]);
        if (sum % 256 == int'(d)) begin
          for (int i = 2; i < m_frame.size(); i++) m_out.push_back(m_frame[i]);
        end else begin
          e_err_chk = 1'b1;
        end
        m_frame.delete();
      end
    end else if (m_frame.size() > 0) begin
      if (m_gap == TIMEOUT - 1) begin
        e_err_tout = 1'b1;
        m_frame.delete();
        m_gap = 0;
      end else begin
        m_gap++;
      end
    end
    e_valid = (m_out.size() > 0);
    e_last  = (m_out.size() == 1);
    e_data  = 8'h00;
    if (e_valid) e_data = m_out[0];
    e_ready = !e_valid;
  endtask

  // ---------------- output log for literal checks ----------------
  logic [8:0] cap [$];
  int cnt_len  = 0;
  int cnt_chk  = 0;
  int cnt_tout = 0;

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap.size()) return 32'(cap[i]);
    return 32'hDEAD;
  endfunction

  task automatic clear_log();
    cap.delete();
    cnt_len  = 0;
    cnt_chk  = 0;
    cnt_tout = 0;
  endtask

  // ---------------- per-cycle compare ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic       prev_last  = 1'b0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (m_armed) begin
        check("s_ready", 32'(o_s_ready), 32'(e_ready));
        check("m_valid", 32'(o_m_valid), 32'(e_valid));
        check("err_len", 32'(o_err_len), 32'(e_err_len));
        check("err_chk", 32'(o_err_chk), 32'(e_err_chk));
        check("err_tout", 32'(o_err_tout), 32'(e_err_tout));
        if (e_valid) begin
          check("m_data", 32'(o_m_data), 32'(e_data));
          check("m_last", 32'(o_m_last), 32'(e_last));
        end
        if (prev_stall) begin
          check("hold_data", 32'(o_m_data), 32'(prev_data));
          check("hold_last", 32'(o_m_last), 32'(prev_last));
        end
        if (o_m_valid && i_m_ready && !i_rst) cap.push_back({o_m_last, o_m_data});
        if (o_err_len)  cnt_len++;
        if (o_err_chk)  cnt_chk++;
        if (o_err_tout) cnt_tout++;
      end
      prev_stall = o_m_valid && !i_m_ready && !i_rst;
      prev_data  = o_m_data;
      prev_last  = o_m_last;
      model_step();
    end
  end

  // ---------------- downstream ready driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      case (rdy_mode)
        0:       i_m_ready = 1'b1;
        1:       i_m_ready = 1'($urandom_range(0, 1));
        default: i_m_ready = 1'b0;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] tx_q [$];

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_s_valid = 1'b1;
    i_s_data  = b;
    @(negedge i_clk);
    while (!o_s_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    check("s_ready_wait", 32'(o_s_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_s_valid = 1'b0;
  endtask

  task automatic send_all();
    foreach (tx_q[i]) send_byte(tx_q[i]);
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    i_s_valid = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (o_m_valid && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    check("drain", 32'(o_m_valid), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    do_reset(3);
    @(negedge i_clk);
    check("rst_s_ready", 32'(o_s_ready), 32'd1);
    check("rst_m_valid", 32'(o_m_valid), 32'd0);
    check("rst_errs", 32'({o_err_len, o_err_chk, o_err_tout}), 32'd0);
    @(posedge i_clk);
    #1;
    clear_log();

    // Good frame: 11 22 33, last on 33.
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_all();
    drain();
    check("good_n", 32'(cap.size()), 32'd3);
    check("good_0", cap_at(0), 32'h011);
    check("good_1", cap_at(1), 32'h022);
    check("good_2", cap_at(2), 32'h133);
    check("good_errs", 32'(cnt_len + cnt_chk + cnt_tout), 32'd0);
    clear_log();

    // Bad checksum then a good frame.
    tx_q = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
    send_all();
    idle(3);
    check("badchk_pulse", 32'(cnt_chk), 32'd1);
    check("badchk_noout", 32'(cap.size()), 32'd0);
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_all();
    drain();
    check("badchk_next_n", 32'(cap.size()), 32'd3);
    check("badchk_next_2", cap_at(2), 32'h133);
    clear_log();

    // Zero length and over-length (17 > MAX_LEN).
    tx_q = '{8'hA5, 8'h00};
    send_all();
    idle(2);
    tx_q = '{8'hA5, 8'h11};
    send_all();
    idle(2);
    check("badlen_pulses", 32'(cnt_len), 32'd2);
    check("badlen_noout", 32'(cap.size()), 32'd0);
    clear_log();

    // Leading garbage is discarded.
    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_all();
    drain();
    check("garbage_n", 32'(cap.size()), 32'd1);
    check("garbage_0", cap_at(0), 32'h17E);
    clear_log();

    // SOF value inside the payload is ordinary data.
    tx_q = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h4C};
    send_all();
    drain();
    check("sofdata_n", 32'(cap.size()), 32'd2);
    check("sofdata_0", cap_at(0), 32'h0A5);
    check("sofdata_1", cap_at(1), 32'h1A5);
    clear_log();

    // Maximum length frame: payload 1..16, CHK 0x98.
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h10);
    for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
    tx_q.push_back(8'h98);
    send_all();
    drain();
    check("maxlen_n", 32'(cap.size()), 32'd16);
    check("maxlen_0", cap_at(0), 32'h001);
    check("maxlen_15", cap_at(15), 32'h110);
    check("maxlen_errs", 32'(cnt_len + cnt_chk + cnt_tout), 32'd0);
    clear_log();

    // Four-byte frame with a randomly stalling downstream.
    rdy_mode = 1;
    tx_q = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h3C};
    send_all();
    drain();
    rdy_mode = 0;
    check("stall_n", 32'(cap.size()), 32'd4);
    check("stall_0", cap_at(0), 32'h0DE);
    check("stall_3", cap_at(3), 32'h1EF);
    clear_log();

    // Inter-byte timeout, then recovery.
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_all();
    idle(110);
    check("tout_pulse", 32'(cnt_tout), 32'd1);
    tx_q = '{8'hA5, 8'h01, 8'h55, 8'h56};
    send_all();
    drain();
    check("tout_next_n", 32'(cap.size()), 32'd1);
    check("tout_next_0", cap_at(0), 32'h155);
    clear_log();

    // Byte arriving exactly when the gap limit is reached wins over the timeout.
    tx_q = '{8'hA5, 8'h01};
    send_all();
    idle(TIMEOUT - 1);
    tx_q = '{8'h33, 8'h34};
    send_all();
    drain();
    check("edge_tout", 32'(cnt_tout), 32'd0);
    check("edge_out", cap_at(0), 32'h133);
    clear_log();

    // Reset mid-frame: no error, next frame fine.
    tx_q = '{8'hA5, 8'h03, 8'h11};
    send_all();
    do_reset(2);
    idle(2);
    tx_q = '{8'hA5, 8'h01, 8'h22, 8'h23};
    send_all();
    drain();
    check("rstframe_errs", 32'(cnt_len + cnt_chk + cnt_tout), 32'd0);
    check("rstframe_n", 32'(cap.size()), 32'd1);
    check("rstframe_0", cap_at(0), 32'h122);
    clear_log();

    // Reset mid-SEND with downstream stalled: frame abandoned silently.
    rdy_mode = 2;
    tx_q = '{8'hA5, 8'h01, 8'h42, 8'h43};
    send_all();
    idle(5);
    check("send_stalled_valid", 32'(o_m_valid), 32'd1);
    check("send_stalled_ready", 32'(o_s_ready), 32'd0);
    do_reset(2);
    rdy_mode = 0;
    idle(4);
    check("rstsend_n", 32'(cap.size()), 32'd0);
    check("rstsend_valid", 32'(o_m_valid), 32'd0);
    check("rstsend_errs", 32'(cnt_len + cnt_chk + cnt_tout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 Parameter MAX_LEN, default 16, is the maximum payload bytes per frame (1..255).
REQ-002 Parameter SOF, default 8'hA5, is the start-of-frame byte value.
REQ-003 Parameter TIMEOUT, default 50000, is the inter-byte gap limit in i_clk cycles (>=2).
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_s_data  input  8  received byte from UART receiver.
REQ-007 i_s_valid  input  1  i_s_data is valid.
REQ-008 o_s_ready  output  1  parser accepts a byte this cycle.
REQ-009 o_m_data  output  8  payload byte out.
REQ-010 o_m_valid  output  1  o_m_data is valid.
REQ-011 o_m_last  output  1  marks the final payload byte of a frame.
REQ-012 i_m_ready  input  1  downstream accepts o_m_data.
REQ-013 o_err_len  output  1  one-cycle pulse: illegal LEN byte.
REQ-014 o_err_chk  output  1  one-cycle pulse: checksum mismatch.
REQ-015 o_err_tout  output  1  one-cycle pulse: inter-byte timeout.

Function
REQ-016 Frame format SHALL be: SOF, LEN, LEN payload bytes, CHK; CHK = (LEN + sum of payload) mod 256.
REQ-017 An input byte SHALL be accepted only in a cycle where i_s_valid and o_s_ready are both 1.
REQ-018 States SHALL be IDLE, LEN, PAYLOAD, CHK, SEND; o_s_ready = 1 in IDLE/LEN/PAYLOAD/CHK, 0 in SEND.
REQ-019 IDLE: accepted byte == SOF -> LEN; any other accepted byte is discarded and the state stays IDLE.
REQ-020 LEN: accepted byte in 1..MAX_LEN -> store length, clear the 8-bit running sum and seed it with LEN, reset write index to 0, go to PAYLOAD.
REQ-021 LEN: accepted byte 0 or > MAX_LEN -> o_err_len pulse next cycle, go to IDLE.
REQ-022 PAYLOAD: each accepted byte is written to buffer[write index] and added to the sum mod 256, and the index increments; on the LEN-th byte go to CHK.
REQ-023 CHK: accepted byte == sum -> SEND with read index 0; mismatch -> o_err_chk pulse next cycle, buffer discarded, go to IDLE.
REQ-024 SEND: o_m_valid = 1, o_m_data = buffer[read index], o_m_last = 1 when read index == length-1.
REQ-025 SEND: o_m_data and o_m_last SHALL hold stable while o_m_valid=1 and i_m_ready=0.
REQ-026 SEND: on o_m_valid and i_m_ready the read index increments; transfer with o_m_last=1 -> IDLE next cycle.
REQ-027 Latency: the first payload byte SHALL be presented on o_m_valid in the cycle after the CHK byte is accepted.
REQ-028 Timeout counter SHALL clear on every accepted byte and on entry to LEN, count in LEN/PAYLOAD/CHK, and be held at 0 in IDLE and SEND.
REQ-029 Counter reaching TIMEOUT-1 without an accepted byte -> o_err_tout pulse next cycle, go to IDLE; a byte accepted in that same cycle takes priority and the timeout does not fire.
REQ-030 Buffer SHALL be MAX_LEN x 8; length/index registers SHALL be $clog2(MAX_LEN+1) bits wide.
REQ-031 At most one error pulse per cycle; error pulses SHALL be 0 otherwise.
REQ-032 A SOF value inside LEN/PAYLOAD/CHK SHALL be treated as ordinary data (no resync).

Reset
REQ-033 While i_rst=1: state=IDLE; o_m_valid, o_m_last, o_err_len, o_err_chk, o_err_tout = 0; o_s_ready = 1 from the first cycle after reset.
REQ-034 Reset mid-frame or mid-SEND SHALL abandon the frame with no error pulse; buffer contents need not be cleared.

Verification
REQ-035 Good frame A5 03 11 22 33 69 -> outputs 11, 22, 33; o_m_last only on 33; no error pulses.
REQ-036 Bad checksum A5 02 01 02 00 -> one o_err_chk pulse; o_m_valid never asserts; next good frame is parsed correctly.
REQ-037 A5 00, then A5 11 with MAX_LEN=16 -> two o_err_len pulses; the state returns to IDLE each time.
REQ-038 Leading garbage 00 FF then A5 01 7E 7F -> single output 7E with o_m_last=1.
REQ-039 Good 4-byte frame with i_m_ready toggling randomly -> o_m_data/o_m_last stable while stalled; o_s_ready=0 throughout SEND.
REQ-040 TIMEOUT=100: A5 02 11 then idle for 100 cycles -> one o_err_tout pulse; a following frame A5 01 55 56 -> output 55.
